// File: rtl/blackjack_pkg.sv
// rtl/blackjack_pkg.sv - shared constants, dealer states and rank helpers for the card shoe
package blackjack_pkg;

  localparam int CARD_W         = 4;
  localparam int NUM_RANKS      = 10;
  localparam int RANK_PER_DECK  = 4;
  localparam int TEN_PER_DECK   = 16;
  localparam int CARDS_PER_DECK = 52;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_SHUFFLE,
    S_PRESENT,
    S_WAIT_LOW
  } dealer_state_t;

  function automatic logic [CARD_W-1:0] next_rank(input logic [CARD_W-1:0] r);
    return (r == 4'd10) ? 4'd1 : r + 4'd1;
  endfunction

  function automatic logic [CARD_W-1:0] legal_rank(input logic [CARD_W-1:0] r);
    return (r == 4'd0 || r > 4'd10) ? 4'd10 : r;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// rtl/card_lfsr.sv - free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11)
module card_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [15:0] lfsr_state
);

  // An all-zero state would lock the LFSR, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'h0001 : SEED;

  logic [15:0] r_lfsr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_lfsr <= SEED_EFF;
    else          r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign lfsr_state = r_lfsr;

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - card shoe: per-rank counters, draw/retry/shuffle FSM, card_rdy handshake
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int          HOLD_CYCLES = 2,
  parameter int          NUM_DECKS   = 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       request_card,
  input  logic       force_en,
  input  logic [3:0] force_value,
  output logic       card_rdy,
  output logic [3:0] card_value,
  output logic [8:0] cards_left,
  output logic       shuffle_pulse
);

  // Rank counters are 8 bits wide so that 16*8 = 128 tens still fit.
  localparam logic [7:0] RANK_FULL  = 8'(RANK_PER_DECK * NUM_DECKS);
  localparam logic [7:0] TEN_FULL   = 8'(TEN_PER_DECK * NUM_DECKS);
  localparam logic [8:0] CARDS_FULL = 9'(CARDS_PER_DECK * NUM_DECKS);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES);

  dealer_state_t r_state, w_state_next;

  logic [7:0]  r_cnt [NUM_RANKS];
  logic [3:0]  r_cand;
  logic        r_first;
  logic [3:0]  r_hold;

  logic [15:0] w_lfsr;
  logic        w_unused_lfsr;
  logic [3:0]  w_n, w_rand, w_cand, w_idx;
  logic        w_avail, w_empty;

  card_lfsr #(.SEED(SEED)) u_lfsr (
    .clock      (clock),
    .reset_n    (reset_n),
    .lfsr_state (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:4];
  assign w_n     = w_lfsr[3:0];
  assign w_rand  = (w_n <= 4'd9) ? w_n + 4'd1 : w_n - 4'd6;
  // Force only steers the first draw cycle; retries walk up from the stored candidate.
  assign w_cand  = !r_first ? r_cand : (force_en ? legal_rank(force_value) : w_rand);
  assign w_idx   = w_cand - 4'd1;
  assign w_avail = (r_cnt[w_idx] != 8'd0);
  assign w_empty = (cards_left == 9'd0);
  assign shuffle_pulse = (r_state == S_SHUFFLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (request_card) w_state_next = S_DRAW;
      S_DRAW:     if (w_empty) w_state_next = S_SHUFFLE;
                  else if (w_avail) w_state_next = S_PRESENT;
      S_SHUFFLE:  w_state_next = S_DRAW;
      S_PRESENT:  if (r_hold == HOLD_LAST) w_state_next = S_WAIT_LOW;
      S_WAIT_LOW: if (!request_card) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_RANKS; i++)
        r_cnt[i] <= (i == NUM_RANKS - 1) ? TEN_FULL : RANK_FULL;
      cards_left <= CARDS_FULL;
      card_rdy   <= 1'b0;
      card_value <= 4'd0;
      r_cand     <= 4'd1;
      r_first    <= 1'b1;
      r_hold     <= 4'd0;
    end else begin
      r_cand  <= next_rank(w_cand);
      r_first <= !(r_state == S_DRAW && !w_empty && !w_avail);
      case (r_state)
        S_DRAW: begin
          if (!w_empty && w_avail) begin
            card_value    <= w_cand;
            r_cnt[w_idx]  <= r_cnt[w_idx] - 8'd1;
            cards_left    <= cards_left - 9'd1;
            card_rdy      <= 1'b1;
            r_hold        <= 4'd1;
          end
        end
        S_SHUFFLE: begin
          for (int i = 0; i < NUM_RANKS; i++)
            r_cnt[i] <= (i == NUM_RANKS - 1) ? TEN_FULL : RANK_FULL;
          cards_left <= CARDS_FULL;
        end
        S_PRESENT: begin
          if (r_hold == HOLD_LAST) card_rdy <= 1'b0;
          else                     r_hold   <= r_hold + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - directed scoreboard bench for card_dealer (NUM_DECKS=1, HOLD_CYCLES=2)
module tb_card_dealer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       request_card = 1'b0;
  logic       force_en = 1'b0;
  logic [3:0] force_value = 4'd0;
  logic       card_rdy;
  logic [3:0] card_value;
  logic [8:0] cards_left;
  logic       shuffle_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int value;
    int lat;
    int left;
    int shuffled;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt[11];
  int   m_left;

  card_dealer #(.HOLD_CYCLES(2), .NUM_DECKS(1), .SEED(16'hACE1)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .request_card  (request_card),
    .force_en      (force_en),
    .force_value   (force_value),
    .card_rdy      (card_rdy),
    .card_value    (card_value),
    .cards_left    (cards_left),
    .shuffle_pulse (shuffle_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reload();
    for (int r = 1; r <= 10; r++) m_cnt[r] = (r == 10) ? 16 : 4;
    m_left = 52;
  endtask

  // Model computes the expected card, latency and remaining count, then pushes them.
  task automatic model_push(input logic [3:0] fv);
    exp_t e;
    int   cand;
    cand = (fv == 0 || fv > 10) ? 10 : int'(fv);
    e.lat = 1;
    e.shuffled = 0;
    if (m_left == 0) begin
      model_reload();
      e.lat += 2;
      e.shuffled = 1;
    end
    while (m_cnt[cand] == 0) begin
      cand = (cand == 10) ? 1 : cand + 1;
      e.lat++;
    end
    m_cnt[cand]--;
    m_left--;
    e.value = cand;
    e.left = m_left;
    exp_q.push_back(e);
  endtask

  task automatic deal(input logic [3:0] fv, input bit verbose);
    exp_t e;
    int   lat, width, pulses, left_after;
    bit   prev_pulse;
    model_push(fv);
    force_en = 1'b1;
    force_value = fv;
    request_card = 1'b1;
    tick();
    lat = 0;
    pulses = 0;
    prev_pulse = 1'b0;
    left_after = -1;
    while (!card_rdy && lat < 40) begin
      tick();
      lat++;
      if (prev_pulse) left_after = int'(cards_left);
      prev_pulse = shuffle_pulse;
      if (shuffle_pulse) pulses++;
    end
    e = exp_q.pop_front();
    if (!card_rdy) begin
      chk("deal_timeout", 32'd0, 32'd1);
    end else begin
      if (verbose || e.value != e.lat) begin
        chk("card_value", 32'(card_value), 32'(e.value));
        chk("latency", 32'(lat), 32'(e.lat));
        chk("cards_left", 32'(cards_left), 32'(e.left));
      end
      if (e.shuffled) begin
        chk("shuffle_pulses", 32'(pulses), 32'd1);
        chk("left_after_shuffle", 32'(left_after), 32'd52);
      end
      width = 1;
      while (width < 20) begin
        tick();
        if (!card_rdy) break;
        width++;
      end
      if (verbose) chk("rdy_width", 32'(width), 32'd2);
    end
    request_card = 1'b0;
    force_en = 1'b0;
    tick();
  endtask

  initial begin
    int highs, rises;
    bit prev;

    model_reload();
    #12;
    chk("reset_cards_left", 32'(cards_left), 32'd52);
    chk("reset_card_rdy", 32'(card_rdy), 32'd0);
    chk("reset_card_value", 32'(card_value), 32'd0);
    chk("reset_shuffle", 32'(shuffle_pulse), 32'd0);
    reset_n = 1'b1;
    tick();

    deal(4'd3, 1'b1);
    for (int i = 0; i < 4; i++) deal(4'd7, 1'b1);
    deal(4'd7, 1'b1);

    // Drain the shoe; forced values 0 and 11 exercise the illegal-rank mapping.
    for (int i = 0; i < 46; i++) deal(4'(i % 12), 1'b1);
    chk("shoe_empty", 32'(cards_left), 32'd0);
    deal(4'd4, 1'b1);

    force_en = 1'b1;
    force_value = 4'd5;
    request_card = 1'b1;
    highs = 0;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (card_rdy) highs++;
      if (card_rdy && !prev) rises++;
      prev = card_rdy;
    end
    m_cnt[5]--;
    m_left--;
    chk("hold_rdy_cycles", 32'(highs), 32'd2);
    chk("hold_rdy_rises", 32'(rises), 32'd1);
    chk("hold_card_value", 32'(card_value), 32'd5);
    chk("hold_cards_left", 32'(cards_left), 32'(m_left));
    request_card = 1'b0;
    tick();
    deal(4'd6, 1'b1);

    force_en = 1'b1;
    force_value = 4'd2;
    request_card = 1'b1;
    for (int i = 0; i < 40 && !card_rdy; i++) tick();
    chk("pre_reset_rdy", 32'(card_rdy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_rdy", 32'(card_rdy), 32'd0);
    chk("async_reset_value", 32'(card_value), 32'd0);
    chk("async_reset_left", 32'(cards_left), 32'd52);
    request_card = 1'b0;
    force_en = 1'b0;
    #10;
    reset_n = 1'b1;
    model_reload();
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (card_rdy) highs++;
    end
    chk("idle_after_reset", 32'(highs), 32'd0);
    chk("left_after_reset", 32'(cards_left), 32'd52);
    deal(4'd10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
